// File: rtl/op_issue_queue_pkg.sv
// ============================================================================
// Module : op_issue_queue_pkg
// Brief  : Shared operation word, opcode enum and helpers for the issue queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package op_issue_queue_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    NO_OP        = 2'd0,
    OP_CT_CT_ADD = 2'd1,
    OP_CT_PT_ADD = 2'd2,
    OP_CT_PT_MUL = 2'd3
  } op_e;

  typedef struct packed {
    op_e              mode;
    logic [IDX_W-1:0] idx1_a;
    logic [IDX_W-1:0] idx1_b;
    logic [IDX_W-1:0] idx2_a;
    logic [IDX_W-1:0] idx2_b;
    logic [IDX_W-1:0] out_a;
    logic [IDX_W-1:0] out_b;
  } operation;

  // All-zero word: NO_OP with every index cleared.
  localparam operation NOP_WORD = '0;

  function automatic operation mk_op(op_e m,
                                     logic [IDX_W-1:0] a1, logic [IDX_W-1:0] b1,
                                     logic [IDX_W-1:0] a2, logic [IDX_W-1:0] b2,
                                     logic [IDX_W-1:0] oa, logic [IDX_W-1:0] ob);
    operation o;
    o.mode   = m;
    o.idx1_a = a1;
    o.idx1_b = b1;
    o.idx2_a = a2;
    o.idx2_b = b2;
    o.out_a  = oa;
    o.out_b  = ob;
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/op_issue_queue_if.sv
// ============================================================================
// Module : op_issue_queue_if
// Brief  : Host/cpu-side signal bundle of the issue queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface op_issue_queue_if
  import op_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             in_valid;
  operation         in_op;
  logic             in_ready;
  logic             flush;
  operation         op;
  logic             done_in;
  logic             busy;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] retired_count;
  logic             timeout_err;
  logic             err_clr;

  modport master (
    output in_valid, in_op, flush, done_in, err_clr,
    input  in_ready, op, busy, level, retired_count, timeout_err
  );

  modport slave (
    input  in_valid, in_op, flush, done_in, err_clr,
    output in_ready, op, busy, level, retired_count, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/op_issue_queue_fifo.sv
// ============================================================================
// Module : op_fifo
// Brief  : Synchronous FIFO with flush; head is shown combinationally.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module op_fifo
  import op_issue_queue_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = operation
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         i_push,
  input  wire T                             i_data,
  input  wire logic                         i_pop,
  input  wire logic                         i_flush,
  output T                                  o_head,
  output logic [$clog2(DEPTH+1)-1:0]        o_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_level != LVL_W'(DEPTH));
  assign w_do_pop  = i_pop  && !i_flush && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/op_issue_queue.sv
// ============================================================================
// Module : op_issue_queue
// Brief  : Buffers operations and issues them one at a time to the cpu,
//          waiting for done with a watchdog; counts retirements.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module op_issue_queue
  import op_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input wire logic         clk,
  input wire logic         reset,
  op_issue_queue_if.slave  bus
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  operation         r_op;
  operation         w_op_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             r_err;
  logic             w_retire;
  logic             w_timeout;

  operation         w_head;
  logic [LVL_W-1:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;

  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == LVL_W'(DEPTH));
  assign w_in_ready = !w_full && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = (r_state == S_IDLE) && !w_empty && !bus.flush;

  op_fifo #(
    .DEPTH (DEPTH),
    .T     (operation)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.in_op),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .o_head  (w_head),
    .o_level (w_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_tmr_nxt   = r_tmr;
    w_retire    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // NO_OP heads are popped and dropped without leaving IDLE.
        if (w_pop && (w_head.mode != NO_OP)) begin
          w_op_nxt    = w_head;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_op_nxt    = NOP_WORD;
        w_tmr_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_tmr_nxt = r_tmr + TMR_W'(1);
        if (bus.done_in) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_op_nxt    = NOP_WORD;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= NOP_WORD;
      r_tmr     <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_tmr   <= w_tmr_nxt;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      if (w_timeout)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.op            = r_op;
  assign bus.busy          = (r_state != S_IDLE) || !w_empty;
  assign bus.level         = w_level;
  assign bus.retired_count = r_retired;
  assign bus.timeout_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_op_issue_queue.sv
// ============================================================================
// Module : tb_op_issue_queue
// Brief  : Directed vector table plus hand sequences for op_issue_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_op_issue_queue;
  import op_issue_queue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic clk;
  logic reset;

  op_issue_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  op_issue_queue #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    operation in_op;
    int       done_dly;     // cycles after issue that done_in is raised; 0 = never
    operation exp_op;
    int       exp_ret_inc;
    bit       exp_err;
  } vec_t;

  vec_t     vecs [5];
  int       errors;
  int       checks;
  int       exp_ret;
  bit       ok;
  int       n;
  int       seen;
  int       since;
  operation cap;
  int       acc;
  int       issued;
  bit       saw_full;
  int       lvl_full;
  bit       took;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_op(input operation o);
    bus.in_valid = 1'b1;
    bus.in_op    = o;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_issue(output bit found);
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.op.mode != NO_OP) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_ret = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = NOP_WORD;
    bus.flush    = 1'b0;
    bus.done_in  = 1'b0;
    bus.err_clr  = 1'b0;

    vecs[0] = '{mk_op(OP_CT_CT_ADD, 1, 2, 3, 4, 5, 6), 2,  mk_op(OP_CT_CT_ADD, 1, 2, 3, 4, 5, 6), 1, 1'b0};
    vecs[1] = '{mk_op(OP_CT_PT_ADD, 7, 8, 9, 10, 11, 12), 1, mk_op(OP_CT_PT_ADD, 7, 8, 9, 10, 11, 12), 1, 1'b0};
    vecs[2] = '{mk_op(OP_CT_PT_MUL, 15, 0, 15, 0, 3, 3), 5, mk_op(OP_CT_PT_MUL, 15, 0, 15, 0, 3, 3), 1, 1'b0};
    vecs[3] = '{mk_op(OP_CT_CT_ADD, 2, 2, 2, 2, 2, 2), TIMEOUT, mk_op(OP_CT_CT_ADD, 2, 2, 2, 2, 2, 2), 1, 1'b0};
    vecs[4] = '{mk_op(OP_CT_PT_MUL, 9, 9, 1, 1, 4, 4), 0, mk_op(OP_CT_PT_MUL, 9, 9, 1, 1, 4, 4), 0, 1'b1};

    repeat (2) tick();
    chk("rst op", bus.op, NOP_WORD);
    chk("rst level", bus.level, 0);
    chk("rst retired", bus.retired_count, 0);
    chk("rst err", bus.timeout_err, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst in_ready", bus.in_ready, 1);
    #2 reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      push_op(vecs[v].in_op);
      wait_issue(ok);
      chk($sformatf("v%0d issued", v), ok, 1);
      chk($sformatf("v%0d op", v), bus.op, vecs[v].exp_op);
      tick();
      chk($sformatf("v%0d op_after", v), bus.op, NOP_WORD);
      chk($sformatf("v%0d busy_wait", v), bus.busy, 1);
      if (vecs[v].done_dly == 0) begin
        n = 0;
        while (bus.busy && n < 200) begin
          tick();
          n++;
        end
        chk($sformatf("v%0d timeout_cycles", v), n, TIMEOUT);
      end else begin
        repeat (vecs[v].done_dly - 1) tick();
        bus.done_in = 1'b1;
        tick();
        bus.done_in = 1'b0;
      end
      exp_ret += vecs[v].exp_ret_inc;
      chk($sformatf("v%0d retired", v), bus.retired_count, exp_ret);
      chk($sformatf("v%0d err", v), bus.timeout_err, vecs[v].exp_err);
      chk($sformatf("v%0d busy_end", v), bus.busy, 0);
      chk($sformatf("v%0d level", v), bus.level, 0);
    end

    // Spurious done while idle.
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    chk("spurious done", bus.retired_count, exp_ret);

    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", bus.timeout_err, 0);

    // Clear coinciding with a timeout: the set must win.
    push_op(mk_op(OP_CT_PT_ADD, 1, 1, 1, 1, 1, 1));
    wait_issue(ok);
    chk("setwin issued", ok, 1);
    tick();
    repeat (TIMEOUT - 1) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("setwin err", bus.timeout_err, 1);
    chk("setwin retired", bus.retired_count, exp_ret);
    chk("setwin busy", bus.busy, 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // NO_OP entries are skipped.
    push_op(NOP_WORD);
    push_op(mk_op(OP_CT_PT_ADD, 3, 4, 5, 6, 7, 8));
    push_op(NOP_WORD);
    seen = 0;
    since = -1;
    cap = NOP_WORD;
    for (int c = 0; c < 16; c++) begin
      if (bus.op != NOP_WORD) begin
        seen++;
        cap = bus.op;
        since = 0;
      end
      bus.done_in = (since == 2);
      tick();
      if (since >= 0) since++;
    end
    bus.done_in = 1'b0;
    exp_ret++;
    chk("nop seen", seen, 1);
    chk("nop op", cap, mk_op(OP_CT_PT_ADD, 3, 4, 5, 6, 7, 8));
    chk("nop retired", bus.retired_count, exp_ret);
    chk("nop level", bus.level, 0);

    // Flush with one op in WAIT and three queued, plus a concurrent push.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = mk_op(OP_CT_CT_ADD, 4'(i), 1, 2, 3, 4, 5);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("flush pre level", bus.level, 3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = mk_op(OP_CT_PT_MUL, 6, 6, 6, 6, 6, 6);
    #1;
    chk("flush in_ready", bus.in_ready, 0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush level", bus.level, 0);
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    exp_ret++;
    chk("flush retired", bus.retired_count, exp_ret);
    repeat (3) tick();
    chk("flush no issue", bus.op, NOP_WORD);
    chk("flush busy", bus.busy, 0);

    // DEPTH+2 ops, never completed: fills, then all time out.
    acc = 0;
    issued = 0;
    saw_full = 1'b0;
    lvl_full = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = mk_op(OP_CT_PT_ADD, 0, 1, 2, 3, 4, 5);
    for (int c = 0; c < 2000; c++) begin
      if (acc == DEPTH + 2 && !bus.busy) break;
      took = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready && !saw_full) begin
        saw_full = 1'b1;
        lvl_full = int'(bus.level);
      end
      tick();
      if (took) begin
        acc++;
        if (acc == DEPTH + 2) bus.in_valid = 1'b0;
        else bus.in_op = mk_op(OP_CT_PT_ADD, 4'(acc), 1, 2, 3, 4, 5);
      end
      if (bus.op != NOP_WORD) issued++;
    end
    bus.in_valid = 1'b0;
    chk("full accepted", acc, DEPTH + 2);
    chk("full drained", bus.busy, 0);
    chk("full seen", saw_full, 1);
    chk("full level", lvl_full, DEPTH);
    chk("full issued", issued, DEPTH + 2);
    chk("full err", bus.timeout_err, 1);
    chk("full retired", bus.retired_count, exp_ret);

    // Asynchronous reset mid-WAIT with four entries queued.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = mk_op(OP_CT_CT_ADD, 1, 4'(i), 1, 1, 1, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("areset pre level", bus.level, 4);
    #2 reset = 1'b0;
    #1;
    chk("areset op", bus.op, NOP_WORD);
    chk("areset level", bus.level, 0);
    chk("areset retired", bus.retired_count, 0);
    chk("areset err", bus.timeout_err, 0);
    chk("areset busy", bus.busy, 0);
    chk("areset in_ready", bus.in_ready, 1);
    #1 reset = 1'b1;
    exp_ret = 0;
    tick();
    push_op(mk_op(OP_CT_PT_MUL, 2, 3, 4, 5, 6, 7));
    wait_issue(ok);
    chk("post issued", ok, 1);
    chk("post op", bus.op, mk_op(OP_CT_PT_MUL, 2, 3, 4, 5, 6, 7));
    tick();
    tick();
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    exp_ret++;
    chk("post retired", bus.retired_count, exp_ret);
    chk("post busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/op_issue_queue.md
# op_issue_queue

Instruction buffer and issue sequencer that sits directly upstream of the `cpu` datapath. It accepts `operation` words from the host/testbench over a valid/ready handshake and buffers them in a FIFO. It issues them to `cpu.op` one at a time, each for exactly one cycle, then drives `NO_OP` until the matching `done_out` returns. It also tracks retired operations and flags operations that never complete (watchdog).

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: max WAIT cycles before an op is abandoned; ≥4.
- `CNT_W`, 16: width of `retired_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host offers `in_op`.
- `in_op` in `operation`: instruction word (mode, idx1_a, idx1_b, idx2_a, idx2_b, out_a, out_b).
- `in_ready` out 1: = !full && !flush (combinational).
- `flush` in 1: discard all queued entries; the in-flight op is unaffected.
- `op` out `operation`: registered; drives `cpu.op`.
- `done_in` in 1: from `cpu.done_out`.
- `busy` out 1: state != IDLE || !empty.
- `level` out $clog2(DEPTH+1): queued entry count.
- `retired_count` out CNT_W: ops completed with `done_in`; wraps modulo 2^CNT_W.
- `timeout_err` out 1: sticky watchdog flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- Push: on `in_valid && in_ready`, `in_op` is written to the tail.
- States:
  - IDLE: if !empty, pop the head.
    - Head mode == `NO_OP`: discard; stay IDLE; no count.
    - Otherwise: load `op_q` <= head, go to ISSUE.
  - ISSUE: `op` = popped instruction for this single cycle; `op_q` <= NO_OP; timer <= 0; go to WAIT.
  - WAIT: `op` = NO_OP; timer increments.
    - `done_in`: `retired_count`++, go to IDLE.
    - Else if timer == TIMEOUT-1: `timeout_err` <= 1, go to IDLE; op is dropped, not counted.
- Single op in flight. This removes all register-file RAW/WAW hazards and prevents `cpu` from re-executing a held op, which is non-idempotent when a destination aliases a source.
- `done_in` outside WAIT is spurious: ignored, not counted.
- `done_in` on the timeout cycle: completion wins; no error.
- Push and pop in the same cycle are allowed, including when empty→non-empty occurs next cycle; `level` is unchanged.
- Full: `in_ready`=0; a held `in_valid` must keep `in_op` stable.
- Flush: read/write pointers and `level` reset in that cycle; a concurrent push is refused (`in_ready`=0); a concurrent IDLE pop is suppressed.
- `err_clr` with a simultaneous timeout: set wins.
- Pointers wrap modulo DEPTH; full/empty are derived from `level`.
- Reset (async, any time, including mid-WAIT): state = IDLE, FIFO empty.
  - Outputs: `op` = NO_OP with all index fields 0, `level`=0, `retired_count`=0, `timeout_err`=0, `busy`=0, `in_ready`=1.

## Timing
- Pop decision at cycle T in IDLE → `op` valid at T+1 (ISSUE) → `cpu` stage1 at T+2 → `done_in` at T+3 → IDLE at T+4.
- Steady-state throughput: one op per 4 cycles.
- Push to visible `level`: 1 cycle.
- Push into an empty queue at T: earliest pop at T+1, `op` at T+2.
- All outputs are registered except `in_ready` and `busy`.

## Structure
- The `operation` struct and `op_e` enum (NO_OP, OP_CT_CT_ADD, OP_CT_PT_ADD, OP_CT_PT_MUL) stay in the shared `types.svh`.
- The issue state enum (IDLE/ISSUE/WAIT) is local.
- One sub-module: `op_fifo`, a synchronous FIFO.
  - Parameters: DEPTH, element type `operation`.
  - Ports: push, pop, flush, head data, level.
- Top level: FSM, watchdog timer, counters.

## Test plan
- Push one CT_CT_ADD (idx 1,2,3,4 → out 5,6) into an empty queue; model `done_in` 2 cycles after issue → `op` equals the word for exactly 1 cycle, then NO_OP; `retired_count`=1; `busy` falls 4 cycles after the pop.
- Push DEPTH+2 ops back-to-back with `done_in` never asserted → `in_ready` drops when `level`=8; each op times out after 64 WAIT cycles; `timeout_err`=1; `retired_count`=0.
- Queue [NO_OP, CT_PT_ADD, NO_OP] → only CT_PT_ADD appears on `op`; `retired_count`=1; `level` reaches 0.
- Assert `flush` in the same cycle as a push while 3 entries are queued and one op is in WAIT → `level`=0, push refused, the in-flight op still retires on `done_in`.
- Assert `done_in` on the exact timeout cycle, and `err_clr` on a timeout cycle → count increments with no error; the set wins over the clear.
- Pull `reset` low mid-WAIT with 4 entries queued → all outputs at reset values immediately (async); after release, a new push issues normally.
